wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares one slave port (e.g. main RAM) between NUM_MASTERS masters (or1200 ibus, or1200 dbus, debug master).
- Sits between the masters and the shared slave.
- Holds a grant for the full bus cycle (wb_cyc high), so registered-feedback bursts (cti/bte) are never split.
- Includes a per-access watchdog that terminates hung slave accesses with an error.

---
 rtl/wb_rr_arbiter_if.sv | 56 +++++
 rtl/wb_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle seen by wb_rr_arbiter.
// Purpose : groups the master-side request/response vectors, the shared-slave
//           request/response signals and the grant vector into one interface.
//           The _i/_o suffixes are from the arbiter's point of view.
// Modports: slave  - the arbiter (it receives the masters' requests)
//           master - the environment: the requesting masters plus the shared slave
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  // master side
  logic [NUM_MASTERS*AW-1:0] wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0] wbm_dat_i;
  logic [NUM_MASTERS*4-1:0]  wbm_sel_i;
  logic [NUM_MASTERS-1:0]    wbm_we_i;
  logic [NUM_MASTERS-1:0]    wbm_cyc_i;
  logic [NUM_MASTERS-1:0]    wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
  logic [DW-1:0]             wbm_dat_o;
  logic [NUM_MASTERS-1:0]    wbm_ack_o;
  logic [NUM_MASTERS-1:0]    wbm_err_o;
  logic [NUM_MASTERS-1:0]    wbm_rty_o;
  // shared slave side
  logic [AW-1:0]             wbs_adr_o;
  logic [DW-1:0]             wbs_dat_o;
  logic [3:0]                wbs_sel_o;
  logic                      wbs_we_o;
  logic                      wbs_cyc_o;
  logic                      wbs_stb_o;
  logic [2:0]                wbs_cti_o;
  logic [1:0]                wbs_bte_o;
  logic [DW-1:0]             wbs_dat_i;
  logic                      wbs_ack_i;
  logic                      wbs_err_i;
  logic                      wbs_rty_i;
  // status
  logic [NUM_MASTERS-1:0]    grant_o;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
           wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o, grant_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
           wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o, grant_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter - round-robin Wishbone B3 arbiter sharing one slave between
// NUM_MASTERS masters. A grant is held for the whole bus cycle (cyc high), so
// bursts are never split. A per-access watchdog answers hung accesses with err.
// Ports:
//   wb_clk_i - clock
//   wb_rst_i - synchronous active-high reset
//   bus      - wb_rr_arbiter_if.slave: master requests in, per-master
//              ack/err/rty and broadcast read data out, shared slave request
//              out and response in, one-hot grant_o out (0 when idle)
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_rr_arbiter_if.slave    bus
);
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]          r_last,  w_last_nxt;
  logic [IW-1:0]          r_gidx,  w_gidx_nxt;
  logic [7:0]             r_wdog,  w_wdog_nxt;

  logic                   w_req_found;
  logic [IW-1:0]          w_req_idx;
  logic                   w_cyc, w_stb, w_we, w_resp, w_to_raw, w_to_err;
  logic [AW-1:0]          w_adr;
  logic [DW-1:0]          w_dat;
  logic [3:0]             w_sel;
  logic [2:0]             w_cti;
  logic [1:0]             w_bte;

  // Rotating priority: scan last+1, last+2, ... and take the first requester.
  always_comb begin
    int idx;
    idx         = 0;
    w_req_found = 1'b0;
    w_req_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(r_last) + k) % NUM_MASTERS;
      if (!w_req_found && bus.wbm_cyc_i[idx]) begin
        w_req_found = 1'b1;
        w_req_idx   = IW'(idx);
      end
    end
  end

  // AND-OR mux of the granted master; r_grant==0 when idle, so all slave
  // request fields fall to 0 with no extra gating.
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    w_cti = '0;
    w_bte = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      w_adr |= bus.wbm_adr_i[m*AW +: AW] & {AW{r_grant[m]}};
      w_dat |= bus.wbm_dat_i[m*DW +: DW] & {DW{r_grant[m]}};
      w_sel |= bus.wbm_sel_i[m*4 +: 4]   & {4{r_grant[m]}};
      w_cti |= bus.wbm_cti_i[m*3 +: 3]   & {3{r_grant[m]}};
      w_bte |= bus.wbm_bte_i[m*2 +: 2]   & {2{r_grant[m]}};
    end
  end

  assign w_cyc  = |(r_grant & bus.wbm_cyc_i);
  assign w_stb  = |(r_grant & bus.wbm_stb_i);
  assign w_we   = |(r_grant & bus.wbm_we_i);
  assign w_resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

  // The stb mask uses the raw timeout (independent of the slave response) so
  // there is no loop stb_o -> slave -> ack_i -> stb_o. The err to the master
  // is suppressed when the slave answers in that same cycle.
  assign w_to_raw = (TIMEOUT != 0) && (r_state == BUSY) && w_stb &&
                    (r_wdog == 8'(TIMEOUT));
  assign w_to_err = w_to_raw && !w_resp;

  always_comb begin
    w_wdog_nxt = r_wdog + 8'd1;
    if (r_state != BUSY || !w_stb || w_resp || w_to_raw)
      w_wdog_nxt = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_gidx_nxt  = r_gidx;
    case (r_state)
      IDLE: if (w_req_found) begin
        w_grant_nxt = NUM_MASTERS'(1) << w_req_idx;
        w_gidx_nxt  = w_req_idx;
        w_state_nxt = BUSY;
      end
      BUSY: if (!w_cyc) begin
        // owner goes to the back of the queue
        w_grant_nxt = '0;
        w_last_nxt  = r_gidx;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_gidx  <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_gidx  <= w_gidx_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  assign bus.wbs_adr_o = w_adr;
  assign bus.wbs_dat_o = w_dat;
  assign bus.wbs_sel_o = w_sel;
  assign bus.wbs_we_o  = w_we;
  assign bus.wbs_cyc_o = w_cyc;
  assign bus.wbs_stb_o = w_stb & ~w_to_raw;
  assign bus.wbs_cti_o = w_cti;
  assign bus.wbs_bte_o = w_bte;

  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.wbm_ack_o = r_grant & {NUM_MASTERS{bus.wbs_ack_i}};
  assign bus.wbm_err_o = r_grant & {NUM_MASTERS{bus.wbs_err_i | w_to_err}};
  assign bus.wbm_rty_o = r_grant & {NUM_MASTERS{bus.wbs_rty_i}};
  assign bus.grant_o   = r_grant;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: one instance with TIMEOUT=255 for
// arbitration/burst/reset/watchdog, one with TIMEOUT=3 for the
// ack-vs-timeout race. Inputs change 2 time units after the rising edge.
module tb_wb_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUM_MASTERS(3), .AW(32), .DW(32)) bus  ();
  wb_rr_arbiter_if #(.NUM_MASTERS(3), .AW(32), .DW(32)) bus3 ();

  wb_rr_arbiter #(.NUM_MASTERS(3), .AW(32), .DW(32), .TIMEOUT(255)) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  wb_rr_arbiter #(.NUM_MASTERS(3), .AW(32), .DW(32), .TIMEOUT(3)) u_dut3 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus3)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] e_oh;
    logic [2:0] cti;
    logic       early;
    int         e;

    bus.wbm_adr_i  = '0; bus.wbm_dat_i  = '0; bus.wbm_sel_i  = '0;
    bus.wbm_we_i   = '0; bus.wbm_cyc_i  = '0; bus.wbm_stb_i  = '0;
    bus.wbm_cti_i  = '0; bus.wbm_bte_i  = '0;
    bus.wbs_dat_i  = '0; bus.wbs_ack_i  = 1'b0; bus.wbs_err_i = 1'b0; bus.wbs_rty_i = 1'b0;
    bus3.wbm_adr_i = '0; bus3.wbm_dat_i = '0; bus3.wbm_sel_i = '0;
    bus3.wbm_we_i  = '0; bus3.wbm_cyc_i = '0; bus3.wbm_stb_i = '0;
    bus3.wbm_cti_i = '0; bus3.wbm_bte_i = '0;
    bus3.wbs_dat_i = '0; bus3.wbs_ack_i = 1'b0; bus3.wbs_err_i = 1'b0; bus3.wbs_rty_i = 1'b0;

    // ---- reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_grant", bus.grant_o, 3'b000);
    chk("rst_cyc",   bus.wbs_cyc_o, 1'b0);
    chk("rst_stb",   bus.wbs_stb_o, 1'b0);
    chk("rst_ack",   bus.wbm_ack_o, 3'b000);
    chk("rst_err",   bus.wbm_err_o, 3'b000);

    // ---- master 1 single read
    bus.wbm_adr_i[32 +: 32] = 32'h100;
    bus.wbm_cyc_i[1] = 1'b1;
    bus.wbm_stb_i[1] = 1'b1;
    #1;
    chk("rd_grant_lat", bus.grant_o, 3'b000);
    chk("rd_cyc_lat",   bus.wbs_cyc_o, 1'b0);
    tick();
    chk("rd_grant", bus.grant_o, 3'b010);
    chk("rd_cyc",   bus.wbs_cyc_o, 1'b1);
    chk("rd_stb",   bus.wbs_stb_o, 1'b1);
    chk("rd_adr",   bus.wbs_adr_o, 32'h100);
    tick();
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = 32'hDEADBEEF;
    #1;
    chk("rd_ack", bus.wbm_ack_o, 3'b010);
    chk("rd_dat", bus.wbm_dat_o, 32'hDEADBEEF);
    tick();
    bus.wbs_ack_i = 1'b0;
    bus.wbm_cyc_i[1] = 1'b0;
    bus.wbm_stb_i[1] = 1'b0;
    #1;
    chk("rd_hold_grant", bus.grant_o, 3'b010);
    chk("rd_cyc_drop",   bus.wbs_cyc_o, 1'b0);
    tick();
    chk("rd_release", bus.grant_o, 3'b000);

    // ---- round robin with all three masters requesting
    do_reset();
    bus.wbm_cyc_i = 3'b111;
    bus.wbm_stb_i = 3'b111;
    tick();
    for (int r = 0; r < 6; r++) begin
      e    = r % 3;
      e_oh = 3'b001 << e;
      chk($sformatf("rr_grant%0d", r), bus.grant_o, e_oh);
      bus.wbs_ack_i = 1'b1;
      #1;
      chk($sformatf("rr_ack%0d", r), bus.wbm_ack_o, e_oh);
      tick();
      bus.wbs_ack_i = 1'b0;
      bus.wbm_cyc_i[e] = 1'b0;
      bus.wbm_stb_i[e] = 1'b0;
      tick();
      chk($sformatf("rr_dead%0d", r), bus.grant_o, 3'b000);
      bus.wbm_cyc_i[e] = 1'b1;
      bus.wbm_stb_i[e] = 1'b1;
      tick();
    end
    bus.wbm_cyc_i = 3'b000;
    bus.wbm_stb_i = 3'b000;
    tick(); tick();

    // ---- master 2 burst while master 0 waits
    do_reset();
    bus.wbm_cyc_i[2] = 1'b1;
    bus.wbm_stb_i[2] = 1'b1;
    bus.wbm_cti_i[6 +: 3] = 3'b010;
    bus.wbm_bte_i[4 +: 2] = 2'b00;
    tick();
    chk("bu_grant", bus.grant_o, 3'b100);
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cti = (b < 3) ? 3'b010 : 3'b111;
      bus.wbm_cti_i[6 +: 3]  = cti;
      bus.wbm_adr_i[64 +: 32] = 32'h200 + 32'(4 * b);
      bus.wbs_ack_i = 1'b1;
      #1;
      chk($sformatf("bu_ack%0d", b), bus.wbm_ack_o, 3'b100);
      chk($sformatf("bu_cti%0d", b), bus.wbs_cti_o, cti);
      chk($sformatf("bu_adr%0d", b), bus.wbs_adr_o, 32'h200 + 32'(4 * b));
      tick();
      chk($sformatf("bu_hold%0d", b), bus.grant_o, 3'b100);
    end
    bus.wbs_ack_i = 1'b0;
    bus.wbm_cyc_i[2] = 1'b0;
    bus.wbm_stb_i[2] = 1'b0;
    tick();
    chk("bu_release", bus.grant_o, 3'b000);
    tick();
    chk("bu_next", bus.grant_o, 3'b001);
    bus.wbm_cyc_i = 3'b000;
    bus.wbm_stb_i = 3'b000;
    bus.wbm_cti_i = '0;
    tick(); tick();

    // ---- watchdog, TIMEOUT=255
    do_reset();
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    tick();
    early = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      if (bus.wbm_err_o != 3'b000 || bus.wbs_stb_o != 1'b1) early = 1'b1;
      tick();
    end
    chk("wd_early", early, 1'b0);
    chk("wd_err",   bus.wbm_err_o, 3'b001);
    chk("wd_stb",   bus.wbs_stb_o, 1'b0);
    chk("wd_cyc",   bus.wbs_cyc_o, 1'b1);
    tick();
    chk("wd_err_pulse", bus.wbm_err_o, 3'b000);
    chk("wd_stb_back",  bus.wbs_stb_o, 1'b1);
    bus.wbm_cyc_i = 3'b000;
    bus.wbm_stb_i = 3'b000;
    tick(); tick();

    // ---- reset in the middle of a master 1 burst
    do_reset();
    bus.wbm_cyc_i[1] = 1'b1;
    bus.wbm_stb_i[1] = 1'b1;
    bus.wbm_cti_i[3 +: 3] = 3'b010;
    tick();
    chk("mr_grant", bus.grant_o, 3'b010);
    bus.wbs_ack_i = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("mr_grant_clr", bus.grant_o, 3'b000);
    chk("mr_cyc_clr",   bus.wbs_cyc_o, 1'b0);
    chk("mr_no_ack",    bus.wbm_ack_o, 3'b000);
    rst = 1'b0;
    bus.wbs_ack_i = 1'b0;
    bus.wbm_cti_i = '0;
    bus.wbm_cyc_i = 3'b011;
    bus.wbm_stb_i = 3'b011;
    tick();
    chk("mr_m0_wins", bus.grant_o, 3'b001);
    bus.wbm_cyc_i = 3'b000;
    bus.wbm_stb_i = 3'b000;
    tick(); tick();

    // ---- TIMEOUT=3: plain timeout, then ack coinciding with timeout
    do_reset();
    bus3.wbm_cyc_i[0] = 1'b1;
    bus3.wbm_stb_i[0] = 1'b1;
    tick();
    chk("t3_grant", bus3.grant_o, 3'b001);
    tick(); tick();
    chk("t3_err_c3", bus3.wbm_err_o, 3'b000);
    tick();
    chk("t3_err_c4", bus3.wbm_err_o, 3'b001);
    chk("t3_stb_c4", bus3.wbs_stb_o, 1'b0);
    tick();
    chk("t3_err_clr", bus3.wbm_err_o, 3'b000);
    chk("t3_stb_on",  bus3.wbs_stb_o, 1'b1);
    tick(); tick(); tick();
    bus3.wbs_ack_i = 1'b1;
    #1;
    chk("t3_race_ack", bus3.wbm_ack_o, 3'b001);
    chk("t3_race_err", bus3.wbm_err_o, 3'b000);
    tick();
    bus3.wbs_ack_i = 1'b0;
    bus3.wbm_cyc_i = 3'b000;
    bus3.wbm_stb_i = 3'b000;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
